// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package ysyx_22040237_lsu_pkg;

  localparam logic [1:0] LS_BYTE  = 2'b00;
  localparam logic [1:0] LS_HALF  = 2'b01;
  localparam logic [1:0] LS_WORD  = 2'b10;
  localparam logic [1:0] LS_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Byte-lane steering for the LSU: misalignment check, store mask/data shift,
// and load data right-shift with sign/zero extension.
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic [1:0]        size_i,
  input  logic              usign_i,
  input  logic [2:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              misalign_o,
  output logic [STRB_W-1:0] wmask_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  localparam logic [STRB_W-1:0] MASK_B = STRB_W'(1);
  localparam logic [STRB_W-1:0] MASK_H = STRB_W'(3);
  localparam logic [STRB_W-1:0] MASK_W = STRB_W'(15);
  localparam logic [STRB_W-1:0] MASK_D = {STRB_W{1'b1}};

  logic [5:0]      shamt_s;
  logic [XLEN-1:0] rsh_s;

  assign shamt_s = {off_i, 3'b000};
  assign rsh_s   = rdata_i >> shamt_s;
  assign wdata_o = wdata_i << shamt_s;

  // Per-size alignment check, lane mask and load extension.
  always_comb begin
    misalign_o = 1'b0;
    wmask_o    = MASK_D;
    rdata_o    = rsh_s;
    case (size_i)
      LS_BYTE: begin
        misalign_o = 1'b0;
        wmask_o    = MASK_B << off_i;
        rdata_o    = {{(XLEN-8){rsh_s[7] & ~usign_i}}, rsh_s[7:0]};
      end
      LS_HALF: begin
        misalign_o = off_i[0];
        wmask_o    = MASK_H << off_i;
        rdata_o    = {{(XLEN-16){rsh_s[15] & ~usign_i}}, rsh_s[15:0]};
      end
      LS_WORD: begin
        misalign_o = (off_i[1:0] != 2'b00);
        wmask_o    = MASK_W << off_i;
        rdata_o    = {{(XLEN-32){rsh_s[31] & ~usign_i}}, rsh_s[31:0]};
      end
      default: begin
        misalign_o = (off_i != 3'b000);
        wmask_o    = MASK_D;
        rdata_o    = rsh_s;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu_ctrl.sv
// Multi-cycle load/store controller: captures one access from execute, runs a
// request/response exchange on the data bus and reports a one-cycle done.
module ysyx_22040237_lsu_ctrl
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic              lsu_load_i,
  input  logic              lsu_store_i,
  input  logic              lsu_usign_i,
  input  logic [1:0]        lsu_size_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic [4:0]        lsu_rd_idx_i,
  output logic              lsu_done_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic [4:0]        lsu_rd_idx_o,
  output logic              lsu_rd_wen_o,
  output logic              lsu_misalign_o,
  output logic              lsu_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_wen_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [STRB_W-1:0] mem_req_wmask_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_rdata_i,
  input  logic              mem_rsp_err_i
);

  lsu_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              req_valid_q, req_valid_d;
  logic              req_wen_q, req_wen_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0] req_wmask_q, req_wmask_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              rd_wen_q, rd_wen_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;
  logic              is_load_q, is_load_d;
  logic              usign_q, usign_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;

  logic              al_usign_s;
  logic [1:0]        al_size_s;
  logic [2:0]        al_off_s;
  logic              al_misalign_s;
  logic [STRB_W-1:0] al_wmask_s;
  logic [XLEN-1:0]   al_wdata_s;
  logic [XLEN-1:0]   al_rdata_s;

  // In IDLE the aligner looks at the live request; afterwards at the captured one.
  always_comb begin
    if (state_q == IDLE) begin
      al_size_s  = lsu_size_i;
      al_usign_s = lsu_usign_i;
      al_off_s   = lsu_addr_i[2:0];
    end else begin
      al_size_s  = size_q;
      al_usign_s = usign_q;
      al_off_s   = off_q;
    end
  end

  ysyx_22040237_lsu_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W)
  ) u_align (
    .size_i     (al_size_s),
    .usign_i    (al_usign_s),
    .off_i      (al_off_s),
    .wdata_i    (lsu_wdata_i),
    .rdata_i    (mem_rsp_rdata_i),
    .misalign_o (al_misalign_s),
    .wmask_o    (al_wmask_s),
    .wdata_o    (al_wdata_s),
    .rdata_o    (al_rdata_s)
  );

  // Next-state and next-output computation for the controller FSM.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    req_valid_d = req_valid_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    rd_out_d    = rd_out_q;
    rd_wen_d    = rd_wen_q;
    misalign_d  = misalign_q;
    err_d       = err_q;
    is_load_d   = is_load_q;
    usign_d     = usign_q;
    size_d      = size_q;
    off_d       = off_q;
    rd_d        = rd_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid_i) begin
          is_load_d = lsu_load_i & ~lsu_store_i;
          usign_d   = lsu_usign_i;
          size_d    = lsu_size_i;
          off_d     = lsu_addr_i[2:0];
          rd_d      = lsu_rd_idx_i;
          ready_d   = 1'b0;
          if ((lsu_load_i | lsu_store_i) && !al_misalign_s) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_wen_d   = lsu_store_i;
            req_addr_d  = {lsu_addr_i[XLEN-1:3], 3'b000};
            req_wdata_d = lsu_store_i ? al_wdata_s : {XLEN{1'b0}};
            req_wmask_d = lsu_store_i ? al_wmask_s : {STRB_W{1'b0}};
          end else begin
            // No-op or misaligned access completes without touching the bus.
            state_d    = DONE;
            done_d     = 1'b1;
            rdata_d    = {XLEN{1'b0}};
            rd_out_d   = lsu_rd_idx_i;
            rd_wen_d   = 1'b0;
            misalign_d = lsu_load_i | lsu_store_i;
            err_d      = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          state_d     = RSP;
          req_valid_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      RSP: begin
        if (mem_rsp_valid_i) begin
          state_d    = DONE;
          done_d     = 1'b1;
          rdata_d    = is_load_q ? al_rdata_s : {XLEN{1'b0}};
          rd_out_d   = rd_q;
          rd_wen_d   = is_load_q & ~mem_rsp_err_i & (rd_q != 5'd0);
          misalign_d = 1'b0;
          err_d      = mem_rsp_err_i;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= {XLEN{1'b0}};
      req_wdata_q <= {XLEN{1'b0}};
      req_wmask_q <= {STRB_W{1'b0}};
      done_q      <= 1'b0;
      rdata_q     <= {XLEN{1'b0}};
      rd_out_q    <= 5'd0;
      rd_wen_q    <= 1'b0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
      is_load_q   <= 1'b0;
      usign_q     <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 3'b000;
      rd_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      rd_out_q    <= rd_out_d;
      rd_wen_q    <= rd_wen_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
      is_load_q   <= is_load_d;
      usign_q     <= usign_d;
      size_q      <= size_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
    end
  end

  assign lsu_ready_o     = ready_q;
  assign lsu_done_o      = done_q;
  assign lsu_rdata_o     = rdata_q;
  assign lsu_rd_idx_o    = rd_out_q;
  assign lsu_rd_wen_o    = rd_wen_q;
  assign lsu_misalign_o  = misalign_q;
  assign lsu_err_o       = err_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wen_o   = req_wen_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wmask_o = req_wmask_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu_ctrl.sv
// Directed bench for the LSU controller; inputs driven and outputs sampled on negedge.
module tb_ysyx_22040237_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i, lsu_ready_o, lsu_load_i, lsu_store_i, lsu_usign_i;
  logic [1:0]  lsu_size_i;
  logic [63:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [4:0]  lsu_rd_idx_i, lsu_rd_idx_o;
  logic        lsu_done_o, lsu_rd_wen_o, lsu_misalign_o, lsu_err_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o, mem_rsp_rdata_i;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i, mem_rsp_err_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040237_lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_load_i(lsu_load_i), .lsu_store_i(lsu_store_i), .lsu_usign_i(lsu_usign_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rd_idx_i(lsu_rd_idx_i), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_rd_idx_o(lsu_rd_idx_o), .lsu_rd_wen_o(lsu_rd_wen_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_err_o(lsu_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .mem_rsp_err_i(mem_rsp_err_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present one access for a single cycle; returns at the negedge after accept.
  task automatic start(input logic ld, input logic st, input logic us, input logic [1:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    lsu_valid_i  = 1'b1;
    lsu_load_i   = ld;
    lsu_store_i  = st;
    lsu_usign_i  = us;
    lsu_size_i   = sz;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wd;
    lsu_rd_idx_i = rd;
    @(negedge clk);
    lsu_valid_i  = 1'b0;
  endtask

  // One-cycle response pulse; returns one negedge later.
  task automatic respond(input logic [63:0] rdata, input logic err);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = rdata;
    mem_rsp_err_i   = err;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
  endtask

  // Load with immediate bus grant: request at +1, response at +2, done at +3.
  task automatic simple_load(input string tag, input logic us, input logic [1:0] sz,
                             input logic [63:0] addr, input logic [4:0] rd,
                             input logic [63:0] rsp, input logic err,
                             input logic [63:0] exp_data, input logic exp_wen);
    start(1'b1, 1'b0, us, sz, addr, 64'd0, rd);
    check_eq({tag, "_req_valid"}, {63'd0, mem_req_valid_o}, 64'd1);
    check_eq({tag, "_req_addr"}, mem_req_addr_o, {addr[63:3], 3'b000});
    check_eq({tag, "_req_wmask"}, {56'd0, mem_req_wmask_o}, 64'd0);
    @(negedge clk);
    respond(rsp, err);
    check_eq({tag, "_done"}, {63'd0, lsu_done_o}, 64'd1);
    check_eq({tag, "_rdata"}, lsu_rdata_o, exp_data);
    check_eq({tag, "_rd_wen"}, {63'd0, lsu_rd_wen_o}, {63'd0, exp_wen});
    check_eq({tag, "_err"}, {63'd0, lsu_err_o}, {63'd0, err});
    check_eq({tag, "_rd_idx"}, {59'd0, lsu_rd_idx_o}, {59'd0, rd});
    @(negedge clk);
    check_eq({tag, "_done_drop"}, {63'd0, lsu_done_o}, 64'd0);
    check_eq({tag, "_ready_back"}, {63'd0, lsu_ready_o}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid_i = 1'b0; lsu_load_i = 1'b0; lsu_store_i = 1'b0; lsu_usign_i = 1'b0;
    lsu_size_i = 2'b00; lsu_addr_i = 64'd0; lsu_wdata_i = 64'd0; lsu_rd_idx_i = 5'd0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 64'd0; mem_rsp_err_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {63'd0, lsu_ready_o}, 64'd1);
    check_eq("rst_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
    check_eq("rst_done", {63'd0, lsu_done_o}, 64'd0);
    check_eq("rst_rdata", lsu_rdata_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    simple_load("lb", 1'b0, 2'b00, 64'h0000_0000_8000_0003, 5'd5,
                64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    simple_load("lbu", 1'b1, 2'b00, 64'h0000_0000_8000_0003, 5'd6,
                64'h0000_0000_8000_0000, 1'b0, 64'h0000_0000_0000_0080, 1'b1);
    simple_load("lw", 1'b0, 2'b10, 64'h0000_0000_8000_0004, 5'd9,
                64'h89AB_CDEF_0123_4567, 1'b0, 64'hFFFF_FFFF_89AB_CDEF, 1'b1);
    simple_load("lwu_err", 1'b1, 2'b10, 64'h0000_0000_8000_0004, 5'd3,
                64'h89AB_CDEF_0123_4567, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b0);
    simple_load("lh_rd0", 1'b0, 2'b01, 64'h0000_0000_8000_0002, 5'd0,
                64'h0000_0000_8001_0000, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);

    // Store halfword into lanes 6..7.
    start(1'b0, 1'b1, 1'b0, 2'b01, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 5'd4);
    check_eq("sh_req_valid", {63'd0, mem_req_valid_o}, 64'd1);
    check_eq("sh_req_addr", mem_req_addr_o, 64'h0000_0000_8000_0000);
    check_eq("sh_wmask", {56'd0, mem_req_wmask_o}, 64'h0000_0000_0000_00C0);
    check_eq("sh_wdata", mem_req_wdata_o, 64'h1234_0000_0000_0000);
    check_eq("sh_wen", {63'd0, mem_req_wen_o}, 64'd1);
    @(negedge clk);
    respond(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check_eq("sh_done", {63'd0, lsu_done_o}, 64'd1);
    check_eq("sh_rd_wen", {63'd0, lsu_rd_wen_o}, 64'd0);
    check_eq("sh_rdata", lsu_rdata_o, 64'd0);
    @(negedge clk);

    // Misaligned word: no bus request, done one cycle after accept.
    start(1'b1, 1'b0, 1'b0, 2'b10, 64'h0000_0000_8000_0002, 64'd0, 5'd7);
    check_eq("mis_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
    check_eq("mis_done", {63'd0, lsu_done_o}, 64'd1);
    check_eq("mis_flag", {63'd0, lsu_misalign_o}, 64'd1);
    check_eq("mis_rd_wen", {63'd0, lsu_rd_wen_o}, 64'd0);
    @(negedge clk);
    check_eq("mis_ready_back", {63'd0, lsu_ready_o}, 64'd1);

    // No-op completes immediately without misalign.
    start(1'b0, 1'b0, 1'b0, 2'b11, 64'h0000_0000_8000_0001, 64'd0, 5'd2);
    check_eq("nop_done", {63'd0, lsu_done_o}, 64'd1);
    check_eq("nop_mis", {63'd0, lsu_misalign_o}, 64'd0);
    check_eq("nop_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
    @(negedge clk);

    // Dword load with the bus stalling for 5 cycles.
    mem_req_ready_i = 1'b0;
    start(1'b1, 1'b0, 1'b1, 2'b11, 64'h0000_0000_8000_0010, 64'd0, 5'd12);
    for (int i = 0; i < 6; i++) begin
      check_eq("ld_stall_valid", {63'd0, mem_req_valid_o}, 64'd1);
      check_eq("ld_stall_addr", mem_req_addr_o, 64'h0000_0000_8000_0010);
      check_eq("ld_stall_ready", {63'd0, lsu_ready_o}, 64'd0);
      if (i == 5) mem_req_ready_i = 1'b1;
      else mem_req_ready_i = 1'b0;
      @(negedge clk);
    end
    check_eq("ld_req_drop", {63'd0, mem_req_valid_o}, 64'd0);
    respond(64'hFEDC_BA98_7654_3210, 1'b0);
    check_eq("ld_done", {63'd0, lsu_done_o}, 64'd1);
    check_eq("ld_rdata", lsu_rdata_o, 64'hFEDC_BA98_7654_3210);
    check_eq("ld_rd_wen", {63'd0, lsu_rd_wen_o}, 64'd1);
    @(negedge clk);

    // Reset while waiting for the response; the late response must be ignored.
    start(1'b1, 1'b0, 1'b0, 2'b11, 64'h0000_0000_8000_0008, 64'd0, 5'd8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_ready", {63'd0, lsu_ready_o}, 64'd1);
    check_eq("rstmid_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
    respond(64'h1111_2222_3333_4444, 1'b0);
    check_eq("rstmid_no_done", {63'd0, lsu_done_o}, 64'd0);
    check_eq("rstmid_rdata", lsu_rdata_o, 64'd0);
    check_eq("rstmid_rd_wen", {63'd0, lsu_rd_wen_o}, 64'd0);
    @(negedge clk);
    check_eq("rstmid_no_done2", {63'd0, lsu_done_o}, 64'd0);
    check_eq("rstmid_ready2", {63'd0, lsu_ready_o}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
